x273_write_arbiter: RTL and testbench

//  Round-robin write arbiter and sequencer for an octal D register with reset (74xx273 style).

---
 rtl/x273_write_arbiter.sv | 129 ++++++++++++
 tb/tb_x273_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/x273_write_arbiter.sv
// Round-robin write arbiter in front of a shared 74xx273-style holding register.
// Requesters win by REQ/ACK handshake; each commit loads data or clears.
module x273_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic                    CP,
   input  logic                    MR,
   input  logic [NREQ-1:0]         REQ,
   input  logic [NREQ-1:0]         CLR,
   input  logic [NREQ*WIDTH-1:0]   WDATA,
   output logic [NREQ-1:0]         ACK,
   output logic [WIDTH-1:0]        Q,
   output logic [$clog2(NREQ)-1:0] OWNER,
   output logic                    BUSY
);

   localparam int IW = $clog2(NREQ);
   localparam int GW = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     win_q, win_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              clr_q, clr_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [GW-1:0]     gcnt_q, gcnt_d;

   logic [NREQ-1:0]   elig;
   logic              found;
   logic [IW-1:0]     win;
   int                j;

   always_comb begin
      elig  = REQ & ~ack_q;
      found = 1'b0;
      win   = '0;
      j     = 0;
      // Scan starts at the pointer so the last winner has lowest priority
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!found && elig[j]) begin
            found = 1'b1;
            win   = IW'(j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      data_d  = data_q;
      clr_d   = clr_q;
      ack_d   = '0;
      q_d     = q_q;
      owner_d = owner_q;
      gcnt_d  = gcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               win_d   = win;
               data_d  = WDATA[int'(win)*WIDTH +: WIDTH];
               clr_d   = CLR[win];
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            q_d        = clr_q ? '0 : data_q;
            ack_d[win_q] = 1'b1;
            owner_d    = win_q;
            ptr_d      = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            if (GAP > 0) begin
               state_d = S_GAP;
               gcnt_d  = GW'(GAP - 1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (gcnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gcnt_d = gcnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CP or negedge MR) begin
      if (!MR) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         data_q  <= '0;
         clr_q   <= 1'b0;
         ack_q   <= '0;
         q_q     <= '0;
         owner_q <= '0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         data_q  <= data_d;
         clr_q   <= clr_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         owner_q <= owner_d;
         gcnt_q  <= gcnt_d;
      end
   end

   assign ACK   = ack_q;
   assign Q     = q_q;
   assign OWNER = owner_q;
   assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_x273_write_arbiter.sv
// Scoreboard bench for x273_write_arbiter: GAP=0 instance for the main
// scenarios, GAP=3 instance for gap spacing and BUSY hold.
module tb_x273_write_arbiter;

   typedef struct {
      logic [7:0] q;
      logic [3:0] ack;
      logic [1:0] own;
      int         sp;
   } exp_t;

   logic        CP;
   logic        MR;
   logic [3:0]  req0, clr0, ack0;
   logic [31:0] wd0;
   logic [7:0]  q0;
   logic [1:0]  own0;
   logic        busy0;
   logic [3:0]  req1, clr1, ack1;
   logic [31:0] wd1;
   logic [7:0]  q1;
   logic [1:0]  own1;
   logic        busy1;

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_chk;
   int   n_err;
   int   cyc;
   int   last0;
   int   last1;
   logic drop0;

   x273_write_arbiter #(.NREQ(4), .WIDTH(8), .GAP(0)) dut0 (
      .CP(CP), .MR(MR), .REQ(req0), .CLR(clr0), .WDATA(wd0),
      .ACK(ack0), .Q(q0), .OWNER(own0), .BUSY(busy0)
   );

   x273_write_arbiter #(.NREQ(4), .WIDTH(8), .GAP(3)) dut1 (
      .CP(CP), .MR(MR), .REQ(req1), .CLR(clr1), .WDATA(wd1),
      .ACK(ack1), .Q(q1), .OWNER(own1), .BUSY(busy1)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   always @(posedge CP) cyc <= cyc + 1;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push0(logic [7:0] q, logic [3:0] a, logic [1:0] o, int sp);
      exp_t e;
      e.q = q; e.ack = a; e.own = o; e.sp = sp;
      sb0.push_back(e);
   endtask

   task automatic push1(logic [7:0] q, logic [3:0] a, logic [1:0] o, int sp);
      exp_t e;
      e.q = q; e.ack = a; e.own = o; e.sp = sp;
      sb1.push_back(e);
   endtask

   always @(posedge CP) begin
      exp_t e;
      #1;
      if (ack0 !== 4'b0) begin
         if (sb0.size() == 0) begin
            chk("dut0_unexpected_ack", int'(ack0), 0);
         end else begin
            e = sb0.pop_front();
            chk("dut0_q", int'(q0), int'(e.q));
            chk("dut0_ack", int'(ack0), int'(e.ack));
            chk("dut0_owner", int'(own0), int'(e.own));
            if (e.sp > 0) chk("dut0_spacing", cyc - last0, e.sp);
         end
         last0 = cyc;
      end
   end

   always @(posedge CP) begin
      exp_t e;
      #1;
      if (ack1 !== 4'b0) begin
         if (sb1.size() == 0) begin
            chk("dut1_unexpected_ack", int'(ack1), 0);
         end else begin
            e = sb1.pop_front();
            chk("dut1_q", int'(q1), int'(e.q));
            chk("dut1_ack", int'(ack1), int'(e.ack));
            chk("dut1_owner", int'(own1), int'(e.own));
            if (e.sp > 0) chk("dut1_spacing", cyc - last1, e.sp);
         end
         last1 = cyc;
      end
   end

   task automatic tick();
      @(negedge CP);
      if (drop0) req0 = req0 & ~ack0;
   endtask

   task automatic wait_quiet(string nm, int lim);
      int n;
      n = 0;
      while ((req0 != 4'b0 || ack0 != 4'b0 || busy0) && n < lim) begin
         tick();
         n++;
      end
      if (n >= lim) chk({nm, "_timeout"}, 1, 0);
   endtask

   task automatic wait_acks(int cnt, int lim);
      int seen;
      int n;
      seen = 0;
      n = 0;
      while (seen < cnt && n < lim) begin
         tick();
         if (ack0 != 4'b0) seen++;
         n++;
      end
      if (n >= lim) chk("alt_timeout", seen, cnt);
   endtask

   initial begin
      int n;
      n_chk = 0; n_err = 0; cyc = 0; last0 = 0; last1 = 0;
      drop0 = 1'b1;
      MR = 1'b0;
      req0 = '0; clr0 = '0; wd0 = '0;
      req1 = '0; clr1 = '0; wd1 = '0;

      // reset state
      #3;
      chk("rst_q", int'(q0), 0);
      chk("rst_ack", int'(ack0), 0);
      chk("rst_owner", int'(own0), 0);
      chk("rst_busy", int'(busy0), 0);
      repeat (2) @(negedge CP);
      MR = 1'b1;
      @(negedge CP);

      // single write from requester 1, latency and BUSY window
      req0 = 4'b0010;
      wd0[15:8] = 8'h55;
      push0(8'h55, 4'b0010, 2'd1, 0);
      @(posedge CP); #2;
      chk("t2_busy_write", int'(busy0), 1);
      chk("t2_q_not_yet", int'(q0), 0);
      @(posedge CP); #2;
      chk("t2_busy_after", int'(busy0), 0);
      chk("t2_ack_cycle", int'(ack0), 4'b0010);
      @(negedge CP);
      req0 = 4'b0;
      @(posedge CP); #2;
      chk("t2_ack_one_cycle", int'(ack0), 0);
      chk("t2_q_hold", int'(q0), 8'h55);
      wait_quiet("t2", 20);

      // load FF then clear from requester 3 despite data 77
      req0 = 4'b0100;
      wd0[23:16] = 8'hFF;
      push0(8'hFF, 4'b0100, 2'd2, 0);
      wait_quiet("t5a", 20);
      req0 = 4'b1000;
      clr0 = 4'b1000;
      wd0[31:24] = 8'h77;
      push0(8'h00, 4'b1000, 2'd3, 0);
      wait_quiet("t5b", 20);
      clr0 = 4'b0;

      // all four requesting, one update every 2 cycles, in order
      wd0 = {8'h44, 8'h33, 8'h22, 8'h11};
      req0 = 4'b1111;
      push0(8'h11, 4'b0001, 2'd0, 0);
      push0(8'h22, 4'b0010, 2'd1, 2);
      push0(8'h33, 4'b0100, 2'd2, 2);
      push0(8'h44, 4'b1000, 2'd3, 2);
      wait_quiet("t3", 40);

      // 0 and 2 held continuously alternate
      drop0 = 1'b0;
      wd0[7:0] = 8'h0F;
      wd0[23:16] = 8'hF0;
      req0 = 4'b0101;
      push0(8'h0F, 4'b0001, 2'd0, 0);
      push0(8'hF0, 4'b0100, 2'd2, 2);
      push0(8'h0F, 4'b0001, 2'd0, 2);
      push0(8'hF0, 4'b0100, 2'd2, 2);
      wait_acks(4, 40);
      req0 = 4'b0;
      drop0 = 1'b1;
      wait_quiet("t4", 20);

      // A5 write, then reset in the middle of a following write
      wd0[15:8] = 8'hA5;
      req0 = 4'b0010;
      push0(8'hA5, 4'b0010, 2'd1, 0);
      wait_quiet("t1a", 20);
      chk("t1_q_a5", int'(q0), 8'hA5);
      wd0[23:16] = 8'h99;
      req0 = 4'b0100;
      @(posedge CP); #2;
      chk("t1_busy_mid", int'(busy0), 1);
      MR = 1'b0;
      #1;
      chk("t1_rst_q", int'(q0), 0);
      chk("t1_rst_ack", int'(ack0), 0);
      chk("t1_rst_busy", int'(busy0), 0);
      chk("t1_rst_owner", int'(own0), 0);
      @(negedge CP);
      wd0[15:8] = 8'h3C;
      wd0[31:24] = 8'h6E;
      req0 = 4'b1110;
      push0(8'h3C, 4'b0010, 2'd1, 0);
      push0(8'h99, 4'b0100, 2'd2, 2);
      push0(8'h6E, 4'b1000, 2'd3, 2);
      MR = 1'b1;
      wait_quiet("t1b", 40);

      // GAP=3 instance: spacing 5 and BUSY held through gap
      @(negedge CP);
      wd1[15:8] = 8'h5A;
      wd1[23:16] = 8'hC3;
      req1 = 4'b0110;
      push1(8'h5A, 4'b0010, 2'd1, 0);
      push1(8'hC3, 4'b0100, 2'd2, 5);
      n = 0;
      do begin
         @(posedge CP); #2;
         n++;
      end while (ack1 == 4'b0 && n < 20);
      if (n >= 20) chk("t6_first_timeout", 0, 1);
      req1 = 4'b0100;
      chk("t6_busy_gap0", int'(busy1), 1);
      @(posedge CP); #2;
      chk("t6_busy_gap1", int'(busy1), 1);
      @(posedge CP); #2;
      chk("t6_busy_gap2", int'(busy1), 1);
      @(posedge CP); #2;
      chk("t6_idle_after_gap", int'(busy1), 0);
      n = 0;
      do begin
         @(posedge CP); #2;
         n++;
      end while (ack1 == 4'b0 && n < 20);
      if (n >= 20) chk("t6_second_timeout", 0, 1);
      req1 = 4'b0;
      repeat (8) @(negedge CP);

      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
